// File: rtl/async_ff_pkg.sv
// Shared constants for the async_flip_flop register bank.
// Optional feature macro: ASYNC_FF_SYNC_CLR_EN (adds synchronous clear input sclr).
package async_ff_pkg;

    // Default bank width: a single-bit flop
    localparam int ASYNC_FF_DEF_WIDTH = 1;

    // Default per-bit reset value; replicated across the bank width
    localparam logic ASYNC_FF_DEF_RST_BIT = 1'b0;

endpackage : async_ff_pkg

// File: rtl/async_ff_bit.sv
// One-bit D flop with clock enable and asynchronous active-high reset.
// Optional feature macro: ASYNC_FF_SYNC_CLR_EN (adds synchronous clear input sclr).
module async_ff_bit (
    input  logic clk,
    input  logic reset,
    input  logic Enable,
`ifdef ASYNC_FF_SYNC_CLR_EN
    input  logic sclr,
`endif
    input  logic d,
    input  logic rst_val,
    output logic q
);

    logic q_r;

`ifdef ASYNC_FF_SYNC_CLR_EN
    // Bit storage: async reset wins, then synchronous clear, then enabled capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= rst_val;
        end else if (sclr) begin
            q_r <= rst_val;
        end else if (Enable) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end
`else
    // Bit storage: async reset wins, otherwise capture only when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= rst_val;
        end else if (Enable) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end
`endif

    assign q = q_r;

endmodule : async_ff_bit

// File: rtl/async_flip_flop.sv
// WIDTH-bit register bank with clock enable and asynchronous active-high reset.
// Q is the registered value; Q_Bar is derived from Q so the two can never agree on a bit.
// Optional feature macro: ASYNC_FF_SYNC_CLR_EN (adds synchronous clear input sclr).
module async_flip_flop
    import async_ff_pkg::*;
#(
    parameter int               WIDTH     = ASYNC_FF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{ASYNC_FF_DEF_RST_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
`ifdef ASYNC_FF_SYNC_CLR_EN
    input  logic             sclr,
`endif
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_Bar
);

    logic [WIDTH-1:0] q_s;

    // One flop per stored bit, each loaded with its own reset value bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        async_ff_bit u_bit (
            .clk     (clk),
            .reset   (reset),
            .Enable  (Enable),
`ifdef ASYNC_FF_SYNC_CLR_EN
            .sclr    (sclr),
`endif
            .d       (Data_in[gi]),
            .rst_val (RESET_VAL[gi]),
            .q       (q_s[gi])
        );
    end

    assign Q     = q_s;
    assign Q_Bar = ~q_s;

endmodule : async_flip_flop

// File: tb/tb_async_flip_flop.sv
// Directed self-checking bench for async_flip_flop (default single-bit build).
// Optional feature macro: ASYNC_FF_SYNC_CLR_EN (exercises the sclr input when defined).
module tb_async_flip_flop;

    logic       clk;
    logic       reset;
    logic       Enable;
    logic [0:0] Data_in;
    logic [0:0] Q;
    logic [0:0] Q_Bar;
`ifdef ASYNC_FF_SYNC_CLR_EN
    logic       sclr;
`endif

    int vectors;
    int miscompares;

    async_flip_flop dut (
        .clk     (clk),
        .reset   (reset),
        .Enable  (Enable),
`ifdef ASYNC_FF_SYNC_CLR_EN
        .sclr    (sclr),
`endif
        .Data_in (Data_in),
        .Q       (Q),
        .Q_Bar   (Q_Bar)
    );

    // Free-running clock, period 100, rising edges at 50, 150, 250, ...
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [0:0] obs, input logic [0:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks Q and its complement against the expected stored value
    task automatic check_q(input string tag, input logic [0:0] exp);
        logic [0:0] exp_bar;
        exp_bar = ~exp;
        check({tag, "_q"}, Q, exp);
        check({tag, "_qbar"}, Q_Bar, exp_bar);
    endtask

    // From edge+1: change Data_in 25 after the edge, confirm no comb path, check after next edge
    task automatic drive_mid(input string tag, input logic [0:0] d, input logic [0:0] prev,
                             input logic [0:0] exp);
        #24;
        Data_in = d;
        #1;
        check({tag, "_nocomb"}, Q, prev);
        @(posedge clk);
        #1;
        check_q(tag, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        Enable      = 1'b0;
        Data_in     = 1'b0;
`ifdef ASYNC_FF_SYNC_CLR_EN
        sclr        = 1'b0;
`endif

        // 1: held in reset with clock running
        #1;
        check_q("rst_t1", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_q("rst_hold", 1'b0);
        end

        // 2: reset release coincident with an edge; that edge must be ignored
        @(negedge clk);
        Enable  = 1'b1;
        Data_in = 1'b1;
        @(posedge clk);
        #0;
        reset = 1'b0;
        #1;
        check_q("rel_edge", 1'b0);
        @(posedge clk);
        #1;
        check_q("rel_next", 1'b1);

        // 3: Data_in 1,0,1,0 changing mid-cycle, Q follows one edge later
        drive_mid("seq0", 1'b1, 1'b1, 1'b1);
        drive_mid("seq1", 1'b0, 1'b1, 1'b0);
        drive_mid("seq2", 1'b1, 1'b0, 1'b1);
        drive_mid("seq3", 1'b0, 1'b1, 1'b0);
        drive_mid("seq4", 1'b1, 1'b0, 1'b1);

        // 4: Enable low holds Q=1 while Data_in toggles
        Enable = 1'b0;
        drive_mid("hold0", 1'b0, 1'b1, 1'b1);
        drive_mid("hold1", 1'b1, 1'b1, 1'b1);
        drive_mid("hold2", 1'b0, 1'b1, 1'b1);

        // 5: async reset pulse between edges
        Data_in = 1'b1;
        #24;
        reset = 1'b1;
        #5;
        check_q("pulse_in", 1'b0);
        #5;
        reset  = 1'b0;
        Enable = 1'b1;
        #1;
        check_q("pulse_after", 1'b0);
        @(posedge clk);
        #1;
        check_q("pulse_next", 1'b1);

`ifdef ASYNC_FF_SYNC_CLR_EN
        // 6: synchronous clear overrides an enabled capture of 1
        sclr = 1'b1;
        @(posedge clk);
        #1;
        check_q("sclr_on", 1'b0);
        sclr = 1'b0;
        @(posedge clk);
        #1;
        check_q("sclr_off", 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_async_flip_flop
